// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode encodings, the queued request payload and
// helpers for recognising 16-bit operations.
package fpu_pkg;

  localparam int unsigned FPU_DATA_W    = 32;
  localparam int unsigned FPU_CTRL_W    = 2;
  // Widest request tag the payload can carry; narrower tags are zero-extended.
  localparam int unsigned FPU_TAG_MAX_W = 8;

  localparam logic [FPU_CTRL_W-1:0] FPU_ADD16 = 2'b00;
  localparam logic [FPU_CTRL_W-1:0] FPU_ADD32 = 2'b01;
  localparam logic [FPU_CTRL_W-1:0] FPU_MUL16 = 2'b10;
  localparam logic [FPU_CTRL_W-1:0] FPU_MUL32 = 2'b11;

  typedef struct packed {
    logic [FPU_DATA_W-1:0]    a;
    logic [FPU_DATA_W-1:0]    b;
    logic [FPU_CTRL_W-1:0]    ctrl;
    logic [FPU_TAG_MAX_W-1:0] tag;
  } fpu_req_t;

  // True for the half-precision opcodes, whose upper 16 bits carry no data.
  function automatic logic is_half(input logic [FPU_CTRL_W-1:0] ctrl);
    return (ctrl == FPU_ADD16) || (ctrl == FPU_MUL16);
  endfunction

endpackage

// File: rtl/fpu_issue_queue_sync_fifo.sv
// Synchronous FIFO with combinational head read and an occupancy count.
//   push/pop   : requests, ignored when full/empty respectively
//   wdata      : entry written at the write pointer
//   head_c     : entry at the read pointer, zero when empty
//   full_c/empty_c : derived from the occupancy count
//   occupancy  : entries currently held (registered)
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    full_c   = (count_q == CNT_W'(DEPTH));
    empty_c  = (count_q == '0);
    do_push  = push && !full_c;
    do_pop   = pop && !empty_c;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    head_c   = empty_c ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign occupancy = count_q;

endmodule

// File: rtl/fpu_issue_queue.sv
// Operand-issue and result-capture stage wrapped around a combinational fpu.
//   in_*       : request handshake (operands, opcode, tag); in_ready = !full
//   fpu_*      : head-of-queue operands/opcode to the fpu, zero when empty
//   fpu_result : combinational result returned by the fpu
//   out_*      : registered result, opcode and tag with valid/ready handshake
//   occupancy  : queued request count
module fpu_issue_queue
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [1:0]             in_ctrl,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic [1:0]             fpu_ctrl,
  input  logic [31:0]            fpu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic [1:0]             out_ctrl,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned REQ_W = $bits(fpu_req_t);

  fpu_req_t          wreq_c, head_c;
  logic              full_c, empty_c, push_c, capture_c;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_result_q, out_result_d;
  logic [1:0]        out_ctrl_q, out_ctrl_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              unused_tag_hi_c;

  // Sanitize on entry, then capture the head result whenever the output slot frees up.
  always_comb begin
    wreq_c.a    = in_a;
    wreq_c.b    = in_b;
    wreq_c.ctrl = in_ctrl;
    wreq_c.tag  = FPU_TAG_MAX_W'(in_tag);
    if (is_half(in_ctrl)) begin
      wreq_c.a[31:16] = '0;
      wreq_c.b[31:16] = '0;
    end

    push_c    = in_valid && !full_c;
    capture_c = !empty_c && (!out_valid_q || out_ready);

    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_ctrl_d   = out_ctrl_q;
    out_tag_d    = out_tag_q;
    if (capture_c) begin
      out_valid_d  = 1'b1;
      out_result_d = is_half(head_c.ctrl) ? {16'h0, fpu_result[15:0]} : fpu_result;
      out_ctrl_d   = head_c.ctrl;
      out_tag_d    = head_c.tag[TAG_W-1:0];
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Tag bits above TAG_W are always zero.
  assign unused_tag_hi_c = ^(head_c.tag >> TAG_W);

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .pop       (capture_c),
    .wdata     (wreq_c),
    .head_c    (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ctrl_q   <= '0;
      out_tag_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ctrl_q   <= out_ctrl_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign in_ready   = !full_c;
  assign fpu_a      = head_c.a;
  assign fpu_b      = head_c.b;
  assign fpu_ctrl   = head_c.ctrl;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ctrl   = out_ctrl_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Scoreboard bench for fpu_issue_queue with a stand-in combinational fpu.
module tb_fpu_issue_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  logic                   clk = 1'b0;
  logic                   reset, in_valid, out_ready;
  logic                   in_ready, out_valid;
  logic [31:0]            in_a, in_b, fpu_a, fpu_b, fpu_result, out_result;
  logic [1:0]             in_ctrl, fpu_ctrl, out_ctrl;
  logic [TAG_W-1:0]       in_tag, out_tag;
  logic [$clog2(DEPTH):0] occupancy;

  typedef struct {
    logic [31:0]      res;
    logic [1:0]       ctrl;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_done = 1'b0;

  logic [31:0] ra [5];
  logic [31:0] rb [5];
  logic [1:0]  rc [5];

  fpu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_tag(in_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_ctrl(fpu_ctrl), .fpu_result(fpu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ctrl(out_ctrl), .out_tag(out_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Stand-in fpu: exact answers for the directed vectors, a scrambler otherwise.
  function automatic logic [31:0] mock_fpu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] c);
    if (c == 2'b01 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (c == 2'b10 && a == 32'h00004000 && b == 32'h00004200) return 32'h00004600;
    return (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]} ^ {30'h0, c} ^ 32'hA5A50000;
  endfunction

  always_comb fpu_result = mock_fpu(fpu_a, fpu_b, fpu_ctrl);

  // Reference: 16-bit ops see only the low halves and report only a low half.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] c, input logic [TAG_W-1:0] t);
    exp_t e;
    bit   half = (c == 2'b00) || (c == 2'b10);
    logic [31:0] sa = half ? (a & 32'h0000FFFF) : a;
    logic [31:0] sbv = half ? (b & 32'h0000FFFF) : b;
    e.res  = mock_fpu(sa, sbv, c);
    if (half) e.res = e.res & 32'h0000FFFF;
    e.ctrl = c;
    e.tag  = t;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every accepted result must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_output: got tag %h result %h with nothing outstanding", out_tag, out_result);
      end else begin
        e = sb_q.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
        chk("out_tag", 32'(out_tag), 32'(e.tag));
      end
    end
  end

  // Drive one request from just after a rising edge until it is accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] c, input logic [TAG_W-1:0] t);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_ctrl = c; in_tag = t;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(a, b, c, t));
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles, tag %h", t);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_ctrl = '0; in_tag = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // add32 latency: head visible one cycle after push, result valid the next
    send(32'h3F800000, 32'h3F800000, 2'b01, 4'd3);
    @(negedge clk);
    chk("lat_valid_n1", 32'(out_valid), 32'd0);
    chk("lat_occ_n1", 32'(occupancy), 32'd1);
    chk("lat_fpu_a", fpu_a, 32'h3F800000);
    @(negedge clk);
    chk("lat_valid_n2", 32'(out_valid), 32'd1);
    chk("add32_result", out_result, 32'h40000000);
    chk("add32_tag", 32'(out_tag), 32'd3);
    chk("add32_ctrl", 32'(out_ctrl), 32'd1);
    @(posedge clk); #1;

    // mul16 sanitizing
    send(32'hDEAD4000, 32'h00004200, 2'b10, 4'd5);
    @(negedge clk);
    chk("mul16_fpu_a", fpu_a, 32'h00004000);
    chk("mul16_fpu_b", fpu_b, 32'h00004200);
    chk("mul16_fpu_ctrl", 32'(fpu_ctrl), 32'd2);
    @(negedge clk);
    chk("mul16_result", out_result, 32'h00004600);

    // Empty queue with consumer ready
    repeat (4) @(negedge clk);
    chk("empty_out_valid", 32'(out_valid), 32'd0);
    chk("empty_fpu_a", fpu_a, 32'd0);
    chk("empty_fpu_b", fpu_b, 32'd0);
    chk("empty_fpu_ctrl", 32'(fpu_ctrl), 32'd0);

    // Backpressure: five pushes fill the result slot plus all entries
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; rc[i] = 2'($urandom_range(0, 3));
    end
    k = 0;
    for (int it = 0; it < 20 && k < 5; it++) begin
      in_valid = 1'b1; in_a = ra[k]; in_b = rb[k]; in_ctrl = rc[k]; in_tag = TAG_W'(k);
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(ra[k], rb[k], rc[k], TAG_W'(k)));
        k++;
      end
      @(posedge clk); #1;
    end
    chk("bp_all_accepted", 32'(k), 32'd5);
    in_valid = 1'b1; in_a = 32'h12345678; in_b = 32'h9ABCDEF0; in_ctrl = 2'b11; in_tag = 4'd9;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_occupancy", 32'(occupancy), 32'd4);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_tag", 32'(out_tag), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_throughput", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at occupancy 2
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 2'($urandom_range(0, 3)), TAG_W'(10 + i));
    @(negedge clk);
    chk("pp_occ_before", 32'(occupancy), 32'd2);
    chk("pp_valid_before", 32'(out_valid), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    send($urandom, $urandom, 2'($urandom_range(0, 3)), 4'd13);
    @(negedge clk);
    chk("pp_occ_after", 32'(occupancy), 32'd2);
    repeat (5) @(negedge clk);

    // Reset with requests queued and a result pending
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, $urandom, 2'($urandom_range(0, 3)), TAG_W'(i));
    @(negedge clk);
    chk("rq_occ_before", 32'(occupancy), 32'd3);
    chk("rq_valid_before", 32'(out_valid), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb_q.delete();
    chk("rq_occ", 32'(occupancy), 32'd0);
    chk("rq_out_valid", 32'(out_valid), 32'd0);
    chk("rq_in_ready", 32'(in_ready), 32'd1);
    chk("rq_out_result", out_result, 32'd0);
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rq_no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic with random backpressure; wraps the pointers many times
    @(posedge clk); #1;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send($urandom, $urandom, 2'($urandom_range(0, 3)), TAG_W'(i));
    end
    rand_done = 1'b1;
    repeat (2) @(posedge clk);
    #2 out_ready = 1'b1;
    for (int i = 0; i < 100 && (sb_q.size() != 0 || out_valid); i++) @(negedge clk);
    chk("final_outstanding", 32'(sb_q.size()), 32'd0);
    chk("final_occupancy", 32'(occupancy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
